// File: rtl/calc_sequencer.sv
// ============================================================================
// calc_sequencer: 8-bit add/sub/iterative-mul/iterative-div command sequencer.
// Optional divider enabled by macro CALC_DIV_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module calc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [7:0]  remainder,
  output logic        error,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;
  logic [15:0] result_q;
  logic [7:0]  rem_out_q;
  logic        error_q;
  logic [2:0]  cnt_q;

  // Shift-add multiplier: multiplicand shifts left, multiplier shifts right.
  logic [15:0] prod_q;
  logic [15:0] mcand_q;
  logic [7:0]  mplier_q;
  logic [15:0] prod_d;

  assign prod_d = prod_q + (mplier_q[0] ? mcand_q : 16'd0);

`ifdef CALC_DIV_EN
  logic        is_div_q;
  logic [7:0]  div_rem_q;
  logic [7:0]  quo_q;
  logic [7:0]  divisor_q;
  logic [8:0]  div_shift;
  logic        div_ge;
  logic [7:0]  rem_d;
  logic [7:0]  quo_d;

  // Restoring step: bring in the next dividend bit, subtract when it fits.
  assign div_shift = {div_rem_q, quo_q[7]};
  assign div_ge    = (div_shift >= {1'b0, divisor_q});
  assign rem_d     = div_ge ? 8'(div_shift - {1'b0, divisor_q}) : div_shift[7:0];
  assign quo_d     = {quo_q[6:0], div_ge};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= 16'd0;
      rem_out_q   <= 8'd0;
      error_q     <= 1'b0;
      cnt_q       <= 3'd0;
      prod_q      <= 16'd0;
      mcand_q     <= 16'd0;
      mplier_q    <= 8'd0;
`ifdef CALC_DIV_EN
      is_div_q    <= 1'b0;
      div_rem_q   <= 8'd0;
      quo_q       <= 8'd0;
      divisor_q   <= 8'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            cnt_q      <= 3'd0;
            rem_out_q  <= 8'd0;
            error_q    <= 1'b0;
            case (op)
              2'b00: begin
                result_q    <= {8'd0, A} + {8'd0, B};
                state_q     <= S_DONE;
                out_valid_q <= 1'b1;
              end
              2'b01: begin
                result_q    <= {8'd0, A} - {8'd0, B};
                state_q     <= S_DONE;
                out_valid_q <= 1'b1;
              end
              2'b10: begin
                prod_q   <= 16'd0;
                mcand_q  <= {8'd0, A};
                mplier_q <= B;
`ifdef CALC_DIV_EN
                is_div_q <= 1'b0;
`endif
                state_q  <= S_BUSY;
                busy_q   <= 1'b1;
              end
              default: begin
`ifdef CALC_DIV_EN
                if (B == 8'd0) begin
                  result_q    <= 16'd0;
                  error_q     <= 1'b1;
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                end else begin
                  is_div_q  <= 1'b1;
                  div_rem_q <= 8'd0;
                  quo_q     <= A;
                  divisor_q <= B;
                  state_q   <= S_BUSY;
                  busy_q    <= 1'b1;
                end
`else
                result_q    <= 16'd0;
                error_q     <= 1'b1;
                state_q     <= S_DONE;
                out_valid_q <= 1'b1;
`endif
              end
            endcase
          end
        end

        S_BUSY: begin
          cnt_q    <= cnt_q + 3'd1;
          prod_q   <= prod_d;
          mcand_q  <= {mcand_q[14:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[7:1]};
`ifdef CALC_DIV_EN
          div_rem_q <= rem_d;
          quo_q     <= quo_d;
`endif
          if (cnt_q == 3'd7) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
`ifdef CALC_DIV_EN
            if (is_div_q) begin
              result_q  <= {8'd0, quo_d};
              rem_out_q <= rem_d;
            end else begin
              result_q  <= prod_d;
            end
`else
            result_q <= prod_d;
`endif
          end
        end

        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign remainder = rem_out_q;
  assign error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// ============================================================================
// tb_calc_sequencer: directed self-checking bench for calc_sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_calc_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [7:0]  remainder;
  logic        error;
  logic        busy;

  int tests_run;
  int tests_failed;

  calc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .remainder (remainder),
    .error     (error),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command, return edges from accept to out_valid and busy cycles seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o,
                        output int lat, output int busy_cnt);
    A = a; B = b; op = o; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_low"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    int bcnt;
    bit stale;
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = 8'd0; B = 8'd0; op = 2'd0;

    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_remainder", remainder, 0);
    check("rst_error", error, 0);
    tick();
    rst = 1'b0;

    run_op(8'd120, 8'd60, 2'b00, lat, bcnt);
    check("add_lat", lat, 1);
    check("add_result", result, 180);
    check("add_rem", remainder, 0);
    check("add_err", error, 0);
    release_result("add");

    run_op(8'd120, 8'd60, 2'b01, lat, bcnt);
    check("sub_lat", lat, 1);
    check("sub_result", result, 60);
    release_result("sub");

    run_op(8'd45, 8'd18, 2'b10, lat, bcnt);
    check("mul_lat", lat, 9);
    check("mul_busy_cycles", bcnt, 8);
    check("mul_result", result, 810);
    check("mul_err", error, 0);
    release_result("mul");

    run_op(8'd18, 8'd45, 2'b01, lat, bcnt);
    check("subneg_result", result, 16'hFFE5);
    release_result("subneg");

    run_op(8'd255, 8'd255, 2'b00, lat, bcnt);
    check("addmax_result", result, 510);
    release_result("addmax");

    run_op(8'd255, 8'd255, 2'b10, lat, bcnt);
    check("mulmax_lat", lat, 9);
    check("mulmax_result", result, 65025);
    release_result("mulmax");

    run_op(8'd45, 8'd18, 2'b11, lat, bcnt);
`ifdef CALC_DIV_EN
    check("div_lat", lat, 9);
    check("div_busy_cycles", bcnt, 8);
    check("div_result", result, 2);
    check("div_rem", remainder, 9);
    check("div_err", error, 0);
`else
    check("div_lat", lat, 1);
    check("div_result", result, 0);
    check("div_rem", remainder, 0);
    check("div_err", error, 1);
`endif
    release_result("div");

`ifdef CALC_DIV_EN
    run_op(8'd200, 8'd7, 2'b11, lat, bcnt);
    check("div2_result", result, 28);
    check("div2_rem", remainder, 4);
    release_result("div2");
`endif

    run_op(8'd80, 8'd0, 2'b11, lat, bcnt);
    check("div0_lat", lat, 1);
    check("div0_result", result, 0);
    check("div0_rem", remainder, 0);
    check("div0_err", error, 1);
    release_result("div0");

    // DONE hold with a competing command that must be ignored.
    run_op(8'd7, 8'd3, 2'b00, lat, bcnt);
    check("hold_first", result, 10);
    A = 8'd1; B = 8'd2; op = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_ov", out_valid, 1);
      check("hold_result", result, 10);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release_ov", out_valid, 0);
    check("hold_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("held_cmd_ov", out_valid, 1);
    check("held_cmd_result", result, 3);
    release_result("held");

    // Reset during the 4th BUSY cycle of a multiply.
    A = 8'd45; B = 8'd18; op = 2'b10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_rem", remainder, 0);
    check("mid_rst_err", error, 0);
    tick();
    rst = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_ov", stale, 0);

    run_op(8'd120, 8'd60, 2'b10, lat, bcnt);
    check("post_rst_mul_lat", lat, 9);
    check("post_rst_mul_result", result, 7200);
    release_result("post_rst");

    // Reset then immediate accept at the first edge after deassertion.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_op(8'd9, 8'd4, 2'b01, lat, bcnt);
    check("first_edge_lat", lat, 1);
    check("first_edge_result", result, 5);
    release_result("first_edge");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  command present on A/B/op.
REQ-005 in_ready  output  1  block can accept a command.
REQ-006 A  input  8  unsigned operand A, sampled on accept.
REQ-007 B  input  8  unsigned operand B, sampled on accept.
REQ-008 op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div; sampled on accept.
REQ-009 out_valid  output  1  result/remainder/error are valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 result  output  16  operation result.
REQ-012 remainder  output  8  division remainder; 0 for other ops.
REQ-013 error  output  1  divide-by-zero or disabled-op flag.
REQ-014 busy  output  1  high while in BUSY.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE; in_ready = (state==IDLE), out_valid = (state==DONE), busy = (state==BUSY).
REQ-016 Accept SHALL occur on a rising edge with in_valid && in_ready; A, B and op are registered at that edge, and inputs are ignored in other states.
REQ-017 Add SHALL give result = zero-extended A+B (max 510), remainder 0, error 0; IDLE->DONE at the accept edge.
REQ-018 Sub SHALL give result = 16-bit two's-complement A-B (e.g. 18-45 = 16'hFFE5), remainder 0, error 0; IDLE->DONE at the accept edge.
REQ-019 Mul SHALL be iterative shift-add, one multiplier bit per cycle, IDLE->BUSY at accept, exactly 8 BUSY cycles, BUSY->DONE on the 8th; out_valid rises 9 edges after accept; result = A*B.
REQ-020 Div with B!=0 SHALL be iterative restoring division, one quotient bit per cycle, same 8-cycle timing as mul; result = zero-extended A/B, remainder = A%B, error 0.
REQ-021 Div with B==0 SHALL skip BUSY: IDLE->DONE at accept edge with result 0, remainder 0, error 1.
REQ-022 A 3-bit iteration counter SHALL count 0..7 in BUSY and reset to 0 on accept.
REQ-023 In DONE, result/remainder/error SHALL stay stable until out_valid && out_ready at a rising edge; DONE->IDLE at that edge.
REQ-024 No bypass: the earliest next accept SHALL be the edge after the DONE->IDLE transition; in_valid held high from the release cycle is accepted one edge later.
REQ-025 out_ready in IDLE or BUSY SHALL have no effect.

Reset
REQ-026 While rst is high, state SHALL be IDLE and in_ready=1, out_valid=0, busy=0, result=0, remainder=0, error=0, counter=0, independent of clk.
REQ-027 Reset in BUSY or DONE SHALL abandon the operation; no out_valid for it is ever produced.
REQ-028 After rst deasserts, the first accept SHALL be possible at the first rising edge.

Configuration
REQ-029 With macro CALC_DIV_EN defined, division SHALL behave per REQ-020/021.
REQ-030 Without CALC_DIV_EN, no divider logic SHALL be built; op 11 SHALL go IDLE->DONE at accept with result 0, remainder 0, error 1 regardless of B, and mul/add/sub are unchanged.

Verification
REQ-031 Reset, then A=120 B=60 op=00 accepted -> out_valid next edge, result 180, remainder 0, error 0; op=01 -> result 60.
REQ-032 A=45 B=18 op=10 -> busy high 8 cycles, out_valid 9 edges after accept, result 810; op=01 with A=18 B=45 -> 16'hFFE5.
REQ-033 A=45 B=18 op=11 (CALC_DIV_EN) -> result 2, remainder 9, error 0 after 9 edges; A=80 B=0 op=11 -> result 0, error 1 after 1 edge.
REQ-034 Hold out_ready low 5 cycles in DONE -> outputs and out_valid stable, in_ready 0, new in_valid ignored; raise out_ready -> IDLE next edge.
REQ-035 Assert rst mid-BUSY (cycle 4 of a mul) -> all outputs 0 immediately, in_ready 1, no stale out_valid; following A=120 B=60 op=10 -> 7200.
REQ-036 Build without CALC_DIV_EN: A=45 B=18 op=11 -> result 0, remainder 0, error 1 one edge after accept.
